pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three sources:
  - load-use hazards in ID,
  - branch/jump redirects resolved in ID,
  - multi-cycle data-memory accesses in MEM.
- Keeps saturating stall/flush performance counters and a sticky timeout error.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use, ID redirects and multi-cycle MEM
// accesses drive the pipeline register enables; stall/flush counters and a sticky timeout.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             memwb_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    hz_state_t       state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt, wait_inc;
    logic            err_nxt;
    logic            lu, rd, ms;

    assign lu = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    assign rd = branch_taken_i || jump_i;
    assign ms = dmem_req_i && !dmem_ready_i;
    assign wait_inc = wait_cnt + TO_W'(1);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err_o    <= err_nxt;
        end
    end

    // Mealy control: freeze in MEM_WAIT/HALT, otherwise LU beats RD.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        err_nxt       = err_o;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_write_o = 1'b1;
        memwb_flush_o = 1'b0;

        if (!rst_i) begin
            unique case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state == ST_RUN) ? ms : !dmem_ready_i) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        exmem_write_o = 1'b0;
                        memwb_flush_o = 1'b1;
                        if (state == ST_RUN) begin
                            state_nxt = ST_MEM_WAIT;
                            wait_nxt  = TO_W'(1);
                        end else begin
                            wait_nxt = wait_inc;
                            if (32'(wait_inc) >= TIMEOUT) begin
                                state_nxt = ST_HALT;
                                err_nxt   = 1'b1;
                            end
                        end
                    end else begin
                        state_nxt = ST_RUN;
                        wait_nxt  = '0;
                        if (lu) begin
                            pc_write_o   = 1'b0;
                            ifid_write_o = 1'b0;
                            idex_flush_o = 1'b1;
                        end else if (rd) begin
                            ifid_flush_o = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    exmem_write_o = 1'b0;
                    memwb_flush_o = 1'b1;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_i (rst_i),
        .inc_i (!pc_write_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_i (rst_i),
        .inc_i (ifid_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two instances (wide and 3-bit counters) against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO  = 4;
    localparam int unsigned WA  = 16;
    localparam int unsigned WB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs = 5'd0, rt = 5'd0, exrt = 5'd0;
    logic       uses_rt = 1'b0, memread = 1'b0, br = 1'b0, jmp = 1'b0;
    logic       req = 1'b0, rdy = 1'b0;

    logic          a_pc, a_ifw, a_iff, a_idf, a_exw, a_mwf, a_err;
    logic [WA-1:0] a_stall, a_flush;
    logic          b_pc, b_ifw, b_iff, b_idf, b_exw, b_mwf, b_err;
    logic [WB-1:0] b_stall, b_flush;

    pipeline_hazard_ctrl #(.CNT_W(WA), .TIMEOUT(TO), .TO_W(3)) dut_a (
        .clk(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
        .idex_memread_i(memread), .idex_rt_i(exrt), .branch_taken_i(br), .jump_i(jmp),
        .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(a_pc), .ifid_write_o(a_ifw), .ifid_flush_o(a_iff), .idex_flush_o(a_idf),
        .exmem_write_o(a_exw), .memwb_flush_o(a_mwf), .err_o(a_err),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
    );

    pipeline_hazard_ctrl #(.CNT_W(WB), .TIMEOUT(TO), .TO_W(3)) dut_b (
        .clk(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
        .idex_memread_i(memread), .idex_rt_i(exrt), .branch_taken_i(br), .jump_i(jmp),
        .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(b_pc), .ifid_write_o(b_ifw), .ifid_flush_o(b_iff), .idex_flush_o(b_idf),
        .exmem_write_o(b_exw), .memwb_flush_o(b_mwf), .err_o(b_err),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: mode 0=running, 1=waiting on memory, 2=halted; raw event counts unsaturated.
    int mode = 0, waited = 0, raw_stall = 0, raw_flush = 0;
    bit m_err = 1'b0;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush}
    localparam logic [5:0] C_NORMAL = 6'b110010;
    localparam logic [5:0] C_FREEZE = 6'b000001;
    localparam logic [5:0] C_LU     = 6'b000110;
    localparam logic [5:0] C_RD     = 6'b111010;

    function automatic logic [5:0] exp_ctrl();
        bit lu, rd, frozen;
        lu = memread && (exrt != 5'd0) && ((exrt == rs) || (uses_rt && (exrt == rt)));
        rd = br || jmp;
        if (rst) return C_NORMAL;
        if (mode == 2) return C_FREEZE;
        frozen = (mode == 0) ? (req && !rdy) : !rdy;
        if (frozen) return C_FREEZE;
        if (lu) return C_LU;
        if (rd) return C_RD;
        return C_NORMAL;
    endfunction

    function automatic longint sat(input int raw, input int unsigned w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (raw > mx) ? mx : longint'(raw);
    endfunction

    always @(posedge clk) begin
        logic [5:0] c;
        int nmode, nwait;
        c = exp_ctrl();
        nmode = mode;
        nwait = waited;
        if (rst) begin
            mode <= 0; waited <= 0; m_err <= 1'b0; raw_stall <= 0; raw_flush <= 0;
        end else begin
            if (!c[5]) raw_stall <= raw_stall + 1;
            if (c[3])  raw_flush <= raw_flush + 1;
            if (mode == 0 && req && !rdy) begin
                nmode = 1; nwait = 1;
            end else if (mode == 1) begin
                if (rdy) begin
                    nmode = 0; nwait = 0;
                end else begin
                    nwait = waited + 1;
                    if (nwait >= int'(TO)) begin
                        nmode = 2; m_err <= 1'b1;
                    end
                end
            end
            mode <= nmode;
            waited <= nwait;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        logic [5:0] c;
        if (cmp_en) begin
            c = exp_ctrl();
            check("ctrl_a", {a_pc, a_ifw, a_iff, a_idf, a_exw, a_mwf}, c);
            check("ctrl_b", {b_pc, b_ifw, b_iff, b_idf, b_exw, b_mwf}, c);
            check("err_a", a_err, m_err);
            check("err_b", b_err, m_err);
            check("stall_a", a_stall, sat(raw_stall, WA));
            check("stall_b", b_stall, sat(raw_stall, WB));
            check("flush_a", a_flush, sat(raw_flush, WA));
            check("flush_b", b_flush, sat(raw_flush, WB));
        end
    end

    task automatic set_id_add();
        rs = 5'd3; rt = 5'd4; uses_rt = 1'b1;
        memread = 1'b0; exrt = 5'd0; br = 1'b0; jmp = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_id_add();
        memread = 1'b1; exrt = 5'd3;
        edge_step();
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_default_ctrl", {a_pc, a_ifw, a_iff, a_idf, a_exw, a_mwf}, 6'b110010);
        edge_step();
        rst = 1'b0;
        set_id_add();
        @(negedge clk);
        check("reset_pc_write", a_pc, 1);
        check("reset_idex_flush", a_idf, 0);
        check("reset_err", a_err, 0);
        check("reset_stall", a_stall, 0);
        check("reset_flush", a_flush, 0);
        edge_step();

        memread = 1'b1; exrt = 5'd5; rs = 5'd5;
        @(negedge clk);
        check("lu_ctrl", {a_pc, a_ifw, a_idf}, 3'b001);
        edge_step();
        check("lu_stall_cnt", a_stall, 1);
        exrt = 5'd0; rs = 5'd0;
        @(negedge clk);
        check("r0_no_stall", a_pc, 1);
        edge_step();
        check("r0_stall_cnt", a_stall, 1);

        exrt = 5'd5; rs = 5'd5; br = 1'b1;
        @(negedge clk);
        check("lu_rd_iff", a_iff, 0);
        check("lu_rd_idf", a_idf, 1);
        edge_step();
        check("lu_rd_flush_cnt", a_flush, 0);
        memread = 1'b0;
        @(negedge clk);
        check("rd_iff", a_iff, 1);
        edge_step();
        check("rd_flush_cnt", a_flush, 1);
        set_id_add();

        req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("memstall_mwf", a_mwf, 1);
            edge_step();
        end
        rdy = 1'b1;
        @(negedge clk);
        check("release_pc", a_pc, 1);
        check("release_mwf", a_mwf, 0);
        edge_step();
        check("memstall_cnt", a_stall, 5);
        set_id_add();
        edge_step();

        req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) edge_step();
        check("pre_timeout_err", a_err, 0);
        edge_step();
        check("timeout_err", a_err, 1);
        rdy = 1'b1;
        @(negedge clk);
        check("halt_hold_pc", a_pc, 0);
        edge_step();
        check("halt_err_sticky", a_err, 1);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        set_id_add();
        check("rst_clears_err", a_err, 0);
        check("rst_clears_stall", a_stall, 0);

        memread = 1'b1; exrt = 5'd7; rs = 5'd7;
        for (int i = 0; i < 10; i++) edge_step();
        check("sat_stall_b", b_stall, 7);
        check("sat_stall_a", a_stall, 10);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            exrt    = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom_range(0, 1));
            memread = ($urandom_range(0, 2) == 0);
            br      = ($urandom_range(0, 3) == 0);
            jmp     = ($urandom_range(0, 7) == 0);
            req     = ($urandom_range(0, 3) == 0);
            rdy     = 1'($urandom_range(0, 1));
            edge_step();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
